// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Releases per-domain resets one stage at a time in index order,
//            waiting for each stage ack; soft reset reruns, ack timeout faults.
// Revision : 1.0
// ============================================================================
module reset_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DELAY = 8,
    parameter int ACK_TIMEOUT = 64,
    localparam int c_IDX_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sw_rst_req,
    input  logic [N_STAGES-1:0] stage_ack,
    output logic [N_STAGES-1:0] rst_out,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [c_IDX_W-1:0]  err_stage
);

    localparam int c_CNT_MAX = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(STAGE_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_ACK_LAST  = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_STAGES - 1);

    localparam logic [2:0] c_ST_ASSERT = 3'd0;
    localparam logic [2:0] c_ST_HOLD   = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_DONE   = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [2:0]             r_state;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [2:0]             w_state_nxt;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic [N_STAGES-1:0]    w_rst_out_nxt;
    logic                   w_terr_nxt;
    logic [c_IDX_W-1:0]     w_es_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    // Deassert synchronizer: cleared asynchronously, fills with ones afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_cnt_inc = (r_cnt == {c_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // State register; outputs are registered alongside from their next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_ASSERT;
            r_idx       <= '0;
            r_cnt       <= '0;
            rst_out     <= '1;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            err_stage   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            rst_out     <= w_rst_out_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            timeout_err <= w_terr_nxt;
            err_stage   <= w_es_nxt;
        end
    end

    // Next-state logic; a soft reset overrides any ack or counter event.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_rst_out_nxt = rst_out;
        w_terr_nxt    = timeout_err;
        w_es_nxt      = err_stage;
        if (sw_rst_req) begin
            w_state_nxt   = c_ST_HOLD;
            w_idx_nxt     = '0;
            w_cnt_nxt     = '0;
            w_rst_out_nxt = '1;
        end else begin
            case (r_state)
                c_ST_ASSERT: begin
                    if (r_sync[SYNC_STAGES-1]) begin
                        w_state_nxt = c_ST_HOLD;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt >= c_HOLD_LAST) begin
                        w_rst_out_nxt[r_idx] = 1'b0;
                        w_state_nxt          = c_ST_WAIT;
                        w_cnt_nxt            = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_ST_WAIT: begin
                    if (stage_ack[r_idx]) begin
                        w_cnt_nxt = '0;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = c_ST_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_state_nxt = c_ST_HOLD;
                        end
                    end else if (r_cnt >= c_ACK_LAST) begin
                        w_state_nxt = c_ST_FAULT;
                        w_terr_nxt  = 1'b1;
                        w_es_nxt    = r_idx;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                c_ST_DONE, c_ST_FAULT: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt   = c_ST_ASSERT;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_rst_out_nxt = '1;
                end
            endcase
        end
    end

    // Output decode from the next state so busy/done register with the state.
    always_comb begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
        if (w_state_nxt == c_ST_DONE) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
        end else if (w_state_nxt == c_ST_FAULT) begin
            w_busy_nxt = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Scenario-table bench with checkpoint scoreboard for reset_sequencer.
// Revision : 1.0
// ============================================================================
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] stage_ack = 4'h0;
    logic [3:0] rst_out;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [1:0] err_stage;

    reset_sequencer #(
        .N_STAGES    (4),
        .SYNC_STAGES (2),
        .STAGE_DELAY (8),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .stage_ack   (stage_ack),
        .rst_out     (rst_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .err_stage   (err_stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         scen;
        int         edge_n;
        logic [3:0] ro;
        logic       b;
        logic       d;
        logic       t;
        logic [1:0] es;
    } chk_t;

    typedef struct {
        logic [3:0] mask;
        int         ack_full;
        int         sw_edge;
        int         sw_len;
        int         glitch;
        int         n_edges;
    } scen_t;

    chk_t  tbl[$];
    chk_t  sb[$];
    scen_t sc[8];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic add(input int s, input int e, input logic [3:0] ro,
                       input logic b, input logic d, input logic t, input logic [1:0] es);
        chk_t c;
        c = '{s, e, ro, b, d, t, es};
        tbl.push_back(c);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_point(input chk_t e);
        n_checks++;
        if (rst_out !== e.ro || busy !== e.b || done !== e.d ||
            timeout_err !== e.t || err_stage !== e.es) begin
            n_fail++;
            $display("FAIL s%0d_edge%0d: got rst_out=%h busy=%b done=%b terr=%b es=%0d expected rst_out=%h busy=%b done=%b terr=%b es=%0d",
                     e.scen, e.edge_n, rst_out, busy, done, timeout_err, err_stage,
                     e.ro, e.b, e.d, e.t, e.es);
        end
    endtask

    initial begin
        chk_t e;

        // mask, ack_full_edge, sw_edge, sw_len, glitch_edge, n_edges
        sc[0] = '{4'hF,    0,   0, 0,  0,  45};  // power-on, all acks high
        sc[1] = '{4'b1011, 0,   0, 0,  0, 100};  // stage 2 never acks
        sc[2] = '{4'b1101, 30,  25, 1, 0,  65};  // soft reset while stage 1 waits
        sc[3] = '{4'b1011, 100, 100, 1, 0, 140}; // soft reset after fault
        sc[4] = '{4'b1110, 15,  15, 1, 0,  55};  // soft reset and ack same edge
        sc[5] = '{4'b1000, 20,  0, 0,  0,  50};  // spurious ack on stage 3
        sc[6] = '{4'hF,    0,   0, 0, 30,  72};  // sub-cycle rst glitch
        sc[7] = '{4'hF,    0,  20, 5,  0,  62};  // soft reset held five cycles

        add(0, 10, 4'hF, 1, 0, 0, 0); add(0, 11, 4'hE, 1, 0, 0, 0);
        add(0, 19, 4'hE, 1, 0, 0, 0); add(0, 20, 4'hC, 1, 0, 0, 0);
        add(0, 29, 4'h8, 1, 0, 0, 0); add(0, 37, 4'h8, 1, 0, 0, 0);
        add(0, 38, 4'h0, 1, 0, 0, 0); add(0, 39, 4'h0, 0, 1, 0, 0);
        add(0, 45, 4'h0, 0, 1, 0, 0);

        add(1, 28, 4'hC, 1, 0, 0, 0); add(1, 29, 4'h8, 1, 0, 0, 0);
        add(1, 92, 4'h8, 1, 0, 0, 0); add(1, 93, 4'h8, 0, 0, 1, 2);
        add(1, 100, 4'h8, 0, 0, 1, 2);

        add(2, 20, 4'hC, 1, 0, 0, 0); add(2, 24, 4'hC, 1, 0, 0, 0);
        add(2, 25, 4'hF, 1, 0, 0, 0); add(2, 32, 4'hF, 1, 0, 0, 0);
        add(2, 33, 4'hE, 1, 0, 0, 0); add(2, 42, 4'hC, 1, 0, 0, 0);
        add(2, 60, 4'h0, 1, 0, 0, 0); add(2, 61, 4'h0, 0, 1, 0, 0);

        add(3, 93, 4'h8, 0, 0, 1, 2); add(3, 99, 4'h8, 0, 0, 1, 2);
        add(3, 100, 4'hF, 1, 0, 1, 2); add(3, 108, 4'hE, 1, 0, 1, 2);
        add(3, 135, 4'h0, 1, 0, 1, 2); add(3, 136, 4'h0, 0, 1, 1, 2);

        add(4, 14, 4'hE, 1, 0, 0, 0); add(4, 15, 4'hF, 1, 0, 0, 0);
        add(4, 22, 4'hF, 1, 0, 0, 0); add(4, 23, 4'hE, 1, 0, 0, 0);
        add(4, 32, 4'hC, 1, 0, 0, 0); add(4, 50, 4'h0, 1, 0, 0, 0);
        add(4, 51, 4'h0, 0, 1, 0, 0);

        add(5, 19, 4'hE, 1, 0, 0, 0); add(5, 20, 4'hE, 1, 0, 0, 0);
        add(5, 28, 4'hC, 1, 0, 0, 0); add(5, 46, 4'h0, 1, 0, 0, 0);
        add(5, 47, 4'h0, 0, 1, 0, 0); add(5, 50, 4'h0, 0, 1, 0, 0);

        add(6, 30, 4'h8, 1, 0, 0, 0); add(6, 40, 4'hF, 1, 0, 0, 0);
        add(6, 41, 4'hE, 1, 0, 0, 0); add(6, 50, 4'hC, 1, 0, 0, 0);
        add(6, 59, 4'h8, 1, 0, 0, 0); add(6, 68, 4'h0, 1, 0, 0, 0);
        add(6, 69, 4'h0, 0, 1, 0, 0);

        add(7, 19, 4'hE, 1, 0, 0, 0); add(7, 20, 4'hF, 1, 0, 0, 0);
        add(7, 24, 4'hF, 1, 0, 0, 0); add(7, 31, 4'hF, 1, 0, 0, 0);
        add(7, 32, 4'hE, 1, 0, 0, 0); add(7, 41, 4'hC, 1, 0, 0, 0);
        add(7, 59, 4'h0, 1, 0, 0, 0); add(7, 60, 4'h0, 0, 1, 0, 0);

        for (int s = 0; s < 8; s++) begin
            foreach (tbl[j]) if (tbl[j].scen == s) sb.push_back(tbl[j]);

            // Reset asserted between edges: outputs must follow without a clock.
            @(posedge clk);
            #1;
            rst        = 1'b1;
            sw_rst_req = 1'b0;
            stage_ack  = 4'h0;
            #1;
            chk($sformatf("s%0d_reset_rst_out", s), int'(rst_out), 15);
            chk($sformatf("s%0d_reset_busy", s), int'(busy), 1);
            chk($sformatf("s%0d_reset_done", s), int'(done), 0);
            chk($sformatf("s%0d_reset_terr", s), int'(timeout_err), 0);
            chk($sformatf("s%0d_reset_es", s), int'(err_stage), 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst = 1'b0;

            for (int k = 1; k <= sc[s].n_edges; k++) begin
                sw_rst_req = (sc[s].sw_len > 0 && k >= sc[s].sw_edge &&
                              k < sc[s].sw_edge + sc[s].sw_len);
                stage_ack  = (sc[s].ack_full != 0 && k >= sc[s].ack_full) ? 4'hF : sc[s].mask;
                @(posedge clk);
                #1;
                while (sb.size() > 0 && sb[0].edge_n == k) begin
                    e = sb.pop_front();
                    chk_point(e);
                end
                if (sc[s].glitch == k) begin
                    #3;
                    rst = 1'b1;
                    #1;
                    chk($sformatf("s%0d_glitch_rst_out", s), int'(rst_out), 15);
                    chk($sformatf("s%0d_glitch_busy", s), int'(busy), 1);
                    chk($sformatf("s%0d_glitch_done", s), int'(done), 0);
                    #2;
                    rst = 1'b0;
                end
            end
            chk($sformatf("s%0d_unvisited_checkpoints", s), sb.size(), 0);
            sb.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
